receptor_fase_serial: RTL and testbench

// - Slave-side receiver for the serial phase-code ports (clock, data, update strobe) driven by the execution stage.
// - Deserialises NELEM phase words of ba bits each and stages them; commits to the output register bank on the update strobe.
// - Flags malformed frames (bit count mismatch, overflow, illegal ba).
// - Sits in each slave FPGA in front of the phase-shifter drivers.

---
 rtl/receptor_fase_serial.sv | 147 ++++++++++++++
 tb/tb_receptor_fase_serial.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_fase_serial.sv
// Slave-side serial phase-code receiver: synchronises the master's bit clock, data and
// update strobe, assembles NELEM words of ba bits, and commits them on a clean frame.
module receptor_fase_serial #(
  parameter int NELEM = 7,
  parameter int WMAX  = 5
) (
  input  logic                  clkMC,
  input  logic                  rstn,
  input  logic                  psClk,
  input  logic                  psData,
  input  logic                  psLatch,
  input  logic [2:0]            ba,
  output logic [NELEM*WMAX-1:0] phaseOut,
  output logic                  updPulse,
  output logic                  frameErr,
  output logic [7:0]            elemCnt
);

  typedef enum logic [1:0] {IDLE, RECV, FULL, CHECK} state_t;

  localparam logic [7:0] NELEM_C = 8'(NELEM);
  localparam logic [2:0] WMAX_C  = 3'(WMAX);

  state_t                  state_q, state_d;
  logic [2:0]              clk_sync_q, clk_sync_d;
  logic [2:0]              lat_sync_q, lat_sync_d;
  logic [1:0]              dat_sync_q, dat_sync_d;
  logic [WMAX-1:0]         word_q, word_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              elem_cnt_q, elem_cnt_d;
  logic                    ovf_q, ovf_d;
  logic [WMAX-1:0]         stage_q [NELEM];
  logic [WMAX-1:0]         stage_d [NELEM];
  logic [NELEM*WMAX-1:0]   phase_out_q, phase_out_d;
  logic                    upd_q, upd_d;
  logic                    frame_err_q, frame_err_d;

  logic                    bit_ev, lat_ev, frame_good;
  logic [2:0]              ba_m1;
  logic [WMAX-1:0]         word_next;
  logic [NELEM*WMAX-1:0]   stage_flat;

  // Stage 1 and 2 resynchronise; stage 3 only serves edge detection.
  assign bit_ev = clk_sync_q[1] & ~clk_sync_q[2];
  assign lat_ev = lat_sync_q[1] & ~lat_sync_q[2];
  assign ba_m1  = ba - 3'd1;

  assign frame_good = (elem_cnt_q == NELEM_C) && (bit_idx_q == 3'd0) && !ovf_q &&
                      (ba != 3'd0) && (ba <= WMAX_C);

  generate
    for (genvar gi = 0; gi < NELEM; gi++) begin : g_flat
      assign stage_flat[gi*WMAX +: WMAX] = stage_q[gi];
    end
  endgenerate

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], psClk};
    lat_sync_d  = {lat_sync_q[1:0], psLatch};
    dat_sync_d  = {dat_sync_q[0], psData};
    state_d     = state_q;
    word_d      = word_q;
    bit_idx_d   = bit_idx_q;
    elem_cnt_d  = elem_cnt_q;
    ovf_d       = ovf_q;
    stage_d     = stage_q;
    phase_out_d = phase_out_q;
    upd_d       = 1'b0;
    frame_err_d = frame_err_q;
    word_next   = {word_q[WMAX-2:0], dat_sync_q[1]};

    case (state_q)
      CHECK: begin
        // Bits arriving here are dropped silently; the frame has already been judged.
        if (frame_good) begin
          phase_out_d = stage_flat;
          upd_d       = 1'b1;
          frame_err_d = 1'b0;
        end else begin
          frame_err_d = 1'b1;
        end
        elem_cnt_d = 8'd0;
        bit_idx_d  = 3'd0;
        ovf_d      = 1'b0;
        word_d     = '0;
        state_d    = IDLE;
      end
      default: begin
        if (bit_ev) begin
          if (state_q == FULL) begin
            ovf_d = 1'b1;
          end else if (bit_idx_q == ba_m1) begin
            // Shift register is cleared per word, so the stored word is already zero-extended.
            for (int k = 0; k < NELEM; k++) begin
              if (elem_cnt_q == 8'(k)) stage_d[k] = word_next;
            end
            elem_cnt_d = elem_cnt_q + 8'd1;
            bit_idx_d  = 3'd0;
            word_d     = '0;
            state_d    = (elem_cnt_q + 8'd1 == NELEM_C) ? FULL : RECV;
          end else begin
            word_d    = word_next;
            bit_idx_d = bit_idx_q + 3'd1;
            state_d   = RECV;
          end
        end
        if (lat_ev) state_d = CHECK;
      end
    endcase
  end

  always_ff @(posedge clkMC) begin
    if (!rstn) begin
      state_q     <= IDLE;
      clk_sync_q  <= '0;
      lat_sync_q  <= '0;
      dat_sync_q  <= '0;
      word_q      <= '0;
      bit_idx_q   <= '0;
      elem_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      phase_out_q <= '0;
      upd_q       <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NELEM; k++) stage_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      lat_sync_q  <= lat_sync_d;
      dat_sync_q  <= dat_sync_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      elem_cnt_q  <= elem_cnt_d;
      ovf_q       <= ovf_d;
      phase_out_q <= phase_out_d;
      upd_q       <= upd_d;
      frame_err_q <= frame_err_d;
      stage_q     <= stage_d;
    end
  end

  assign phaseOut = phase_out_q;
  assign updPulse = upd_q;
  assign frameErr = frame_err_q;
  assign elemCnt  = elem_cnt_q;

endmodule

// File: tb/tb_receptor_fase_serial.sv
// Scoreboard bench for receptor_fase_serial: expected commits are queued at latch time
// and compared by a monitor whenever the receiver pulses updPulse.
module tb_receptor_fase_serial;

  localparam int NELEM = 7;
  localparam int WMAX  = 5;
  localparam int W     = NELEM * WMAX;

  logic         clkMC = 1'b0;
  logic         rstn = 1'b0;
  logic         psClk = 1'b0;
  logic         psData = 1'b0;
  logic         psLatch = 1'b0;
  logic [2:0]   ba = 3'd5;
  logic [W-1:0] phaseOut;
  logic         updPulse;
  logic         frameErr;
  logic [7:0]   elemCnt;

  int n_checks = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  logic prev_upd = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_commit = '0;

  receptor_fase_serial #(.NELEM(NELEM), .WMAX(WMAX)) dut (
    .clkMC(clkMC), .rstn(rstn), .psClk(psClk), .psData(psData), .psLatch(psLatch),
    .ba(ba), .phaseOut(phaseOut), .updPulse(updPulse), .frameErr(frameErr), .elemCnt(elemCnt)
  );

  always #5 clkMC = ~clkMC;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  // Commit monitor: every pulse must match the oldest queued expectation.
  always @(negedge clkMC) begin
    if (rstn) begin
      if (updPulse) begin
        pulse_cnt = pulse_cnt + 1;
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL commit_unexpected: updPulse with phaseOut=%h, required no pulse", phaseOut);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (phaseOut !== e) begin
            n_bad = n_bad + 1;
            $display("FAIL commit_data: phaseOut=%h required=%h", phaseOut, e);
          end else begin
            $display("commit ok: phaseOut=%h", phaseOut);
          end
        end
        n_checks = n_checks + 1;
        if (prev_upd) begin
          n_bad = n_bad + 1;
          $display("FAIL pulse_width: updPulse high for more than one cycle, required 1");
        end
      end
    end
    prev_upd = updPulse;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clkMC);
    #1;
  endtask

  task automatic send_bit(input logic b);
    psData = b;
    cycles(2);
    psClk = 1'b1;
    cycles(4);
    psClk = 1'b0;
    cycles(4);
  endtask

  task automatic send_word(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [4:0] c [NELEM], output logic [W-1:0] packed_exp);
    packed_exp = '0;
    for (int k = 0; k < NELEM; k++) begin
      send_word({3'b000, c[k]}, 5);
      packed_exp[k*WMAX +: WMAX] = c[k];
    end
  endtask

  task automatic do_latch();
    psLatch = 1'b1;
    cycles(4);
    psLatch = 1'b0;
    cycles(8);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      psClk = ~psClk;
      cycles(1);
    end
    psClk = 1'b0;
    n_checks = n_checks + 1;
    if (phaseOut !== '0 || elemCnt !== 8'd0 || frameErr !== 1'b0 || updPulse !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_state: phaseOut=%h elemCnt=%0d frameErr=%b updPulse=%b required all zero",
               phaseOut, elemCnt, frameErr, updPulse);
    end else $display("reset ok");
    rstn = 1'b1;
    cycles(3);
  endtask

  task automatic test_ba5();
    logic [4:0] c [NELEM];
    logic [W-1:0] e;
    int p0;
    c = '{5'h01, 5'h1F, 5'h0A, 5'h15, 5'h00, 5'h10, 5'h07};
    ba = 3'd5;
    p0 = pulse_cnt;
    send_frame(c, e);
    n_checks = n_checks + 1;
    if (elemCnt !== 8'd7) begin
      n_bad = n_bad + 1;
      $display("FAIL ba5_count: elemCnt=%0d required=7", elemCnt);
    end
    exp_q.push_back(e);
    do_latch();
    last_commit = e;
    n_checks = n_checks + 1;
    if (pulse_cnt !== p0 + 1 || frameErr !== 1'b0 || elemCnt !== 8'd0) begin
      n_bad = n_bad + 1;
      $display("FAIL ba5_commit: pulses=%0d frameErr=%b elemCnt=%0d required pulses=1 frameErr=0 elemCnt=0",
               pulse_cnt - p0, frameErr, elemCnt);
    end else $display("ba5 frame ok");
  endtask

  task automatic test_ba3();
    logic [W-1:0] e;
    int p0;
    ba = 3'd3;
    p0 = pulse_cnt;
    e = '0;
    for (int k = 0; k < NELEM; k++) begin
      send_word(8'b0000_0101, 3);
      e[k*WMAX +: WMAX] = 5'b00101;
    end
    exp_q.push_back(e);
    do_latch();
    last_commit = e;
    n_checks = n_checks + 1;
    if (pulse_cnt !== p0 + 1 || frameErr !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL ba3_commit: pulses=%0d frameErr=%b required pulses=1 frameErr=0",
               pulse_cnt - p0, frameErr);
    end else $display("ba3 frame ok");
  endtask

  task automatic test_short_frame();
    logic [4:0] c [NELEM];
    logic [W-1:0] e;
    int p0;
    ba = 3'd5;
    p0 = pulse_cnt;
    for (int k = 0; k < 6; k++) send_word(8'h1B, 5);
    send_word(8'h0F, 4);
    do_latch();
    n_checks = n_checks + 1;
    if (frameErr !== 1'b1 || pulse_cnt !== p0 || phaseOut !== last_commit) begin
      n_bad = n_bad + 1;
      $display("FAIL short_frame: frameErr=%b pulses=%0d phaseOut=%h required frameErr=1 pulses=0 phaseOut=%h",
               frameErr, pulse_cnt - p0, phaseOut, last_commit);
    end else $display("short frame rejected ok");
    c = '{5'h1E, 5'h03, 5'h11, 5'h08, 5'h1C, 5'h05, 5'h19};
    p0 = pulse_cnt;
    send_frame(c, e);
    exp_q.push_back(e);
    do_latch();
    last_commit = e;
    n_checks = n_checks + 1;
    if (frameErr !== 1'b0 || pulse_cnt !== p0 + 1) begin
      n_bad = n_bad + 1;
      $display("FAIL short_recover: frameErr=%b pulses=%0d required frameErr=0 pulses=1",
               frameErr, pulse_cnt - p0);
    end else $display("recovery after short frame ok");
  endtask

  task automatic test_overflow();
    logic [4:0] c [NELEM];
    logic [W-1:0] e;
    int p0;
    ba = 3'd5;
    p0 = pulse_cnt;
    for (int k = 0; k < NELEM; k++) send_word(8'h15, 5);
    send_bit(1'b1);
    n_checks = n_checks + 1;
    if (elemCnt !== 8'd7) begin
      n_bad = n_bad + 1;
      $display("FAIL overflow_count: elemCnt=%0d required=7", elemCnt);
    end
    do_latch();
    n_checks = n_checks + 1;
    if (frameErr !== 1'b1 || pulse_cnt !== p0 || elemCnt !== 8'd0 || phaseOut !== last_commit) begin
      n_bad = n_bad + 1;
      $display("FAIL overflow_frame: frameErr=%b pulses=%0d elemCnt=%0d phaseOut=%h required 1/0/0/%h",
               frameErr, pulse_cnt - p0, elemCnt, phaseOut, last_commit);
    end else $display("overflow frame rejected ok");
    c = '{5'h02, 5'h04, 5'h06, 5'h08, 5'h0A, 5'h0C, 5'h0E};
    p0 = pulse_cnt;
    send_frame(c, e);
    exp_q.push_back(e);
    do_latch();
    last_commit = e;
    n_checks = n_checks + 1;
    if (frameErr !== 1'b0 || pulse_cnt !== p0 + 1) begin
      n_bad = n_bad + 1;
      $display("FAIL overflow_recover: frameErr=%b pulses=%0d required frameErr=0 pulses=1",
               frameErr, pulse_cnt - p0);
    end else $display("recovery after overflow ok");
  endtask

  task automatic test_illegal_ba();
    int p0;
    ba = 3'd6;
    p0 = pulse_cnt;
    for (int k = 0; k < NELEM; k++) send_word(8'h2A, 6);
    do_latch();
    n_checks = n_checks + 1;
    if (frameErr !== 1'b1 || pulse_cnt !== p0 || phaseOut !== last_commit) begin
      n_bad = n_bad + 1;
      $display("FAIL illegal_ba: frameErr=%b pulses=%0d phaseOut=%h required frameErr=1 pulses=0 phaseOut=%h",
               frameErr, pulse_cnt - p0, phaseOut, last_commit);
    end else $display("illegal ba rejected ok");
    ba = 3'd5;
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] c [NELEM];
    logic [W-1:0] e;
    int p0;
    ba = 3'd5;
    for (int k = 0; k < 4; k++) send_word(8'h1F, 5);
    rstn = 1'b0;
    cycles(3);
    n_checks = n_checks + 1;
    if (elemCnt !== 8'd0 || phaseOut !== '0 || frameErr !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL mid_reset: elemCnt=%0d phaseOut=%h frameErr=%b required all zero",
               elemCnt, phaseOut, frameErr);
    end
    rstn = 1'b1;
    cycles(3);
    c = '{5'h13, 5'h0F, 5'h01, 5'h1B, 5'h06, 5'h17, 5'h0D};
    p0 = pulse_cnt;
    send_frame(c, e);
    exp_q.push_back(e);
    do_latch();
    last_commit = e;
    n_checks = n_checks + 1;
    if (frameErr !== 1'b0 || pulse_cnt !== p0 + 1 || exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL mid_reset_commit: frameErr=%b pulses=%0d pending=%0d required 0/1/0",
               frameErr, pulse_cnt - p0, exp_q.size());
    end else $display("frame after mid-frame reset ok");
  endtask

  initial begin
    test_reset();
    test_ba5();
    test_ba3();
    test_short_frame();
    test_overflow();
    test_illegal_ba();
    test_reset_mid_frame();
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL pending_commits: %0d expected commits never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
